xsr_rxq: RTL and testbench

XSR_RXQ -- requirements
Module: xsr_rxq

---
 rtl/xsr_pkg.sv | 13 +
 rtl/xsr_fifo.sv | 65 ++++++
 rtl/xsr_rxq.sv | 132 +++++++++++++
 tb/tb_xsr_rxq.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/xsr_pkg.sv
// Shared defaults and sizing helpers for the xsr serial receive queue.
package xsr_pkg;

  localparam int XSR_DATA_W = 64;
  localparam int XSR_BAUD_W = 32;
  localparam int XSR_DEPTH  = 4;

  // Occupancy needs to represent 0..depth inclusive.
  function automatic int lvl_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/xsr_fifo.sv
// Power-of-two receive queue; head word is registered state, gated to zero when empty.
module xsr_fifo
  import xsr_pkg::*;
#(
  parameter int DATA_W = XSR_DATA_W,
  parameter int DEPTH  = XSR_DEPTH
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     push_i,
  input  logic [DATA_W-1:0]        wdata_i,
  input  logic                     pop_i,
  output logic [DATA_W-1:0]        rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [lvl_w(DEPTH)-1:0]  level_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = lvl_w(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]     wp_q, wp_d, rp_q, rp_d;
  logic [LW-1:0]     cnt_q, cnt_d;
  logic              do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == LW'(DEPTH));
  assign level_o = cnt_q;
  assign rdata_o = empty_o ? '0 : mem_q[rp_q];

  // A pop frees the head slot in the same cycle, so a full queue still accepts.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    wp_d  = wp_q;
    rp_d  = rp_q;
    cnt_d = cnt_q;
    if (do_push) wp_d = wp_q + PW'(1);
    if (do_pop)  rp_d = rp_q + PW'(1);
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + LW'(1);
      2'b01:   cnt_d = cnt_q - LW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wp_q] <= wdata_i;
  end

endmodule

// File: rtl/xsr_rxq.sv
// Edge-resynchronised serial receiver assembling variable-length frames into a queue.
module xsr_rxq
  import xsr_pkg::*;
#(
  parameter int DATA_W = XSR_DATA_W,
  parameter int BAUD_W = XSR_BAUD_W,
  parameter int DEPTH  = XSR_DEPTH
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic [$clog2(DATA_W+1)-1:0]  bits_i,
  input  logic [BAUD_W-1:0]            baud_i,
  input  logic                         msb_first_i,
  input  logic                         rxd_i,
  input  logic                         rxc_i,
  input  logic                         rx_ready_i,
  input  logic                         ovr_clr_i,
  output logic [DATA_W-1:0]            rx_data_o,
  output logic                         rx_valid_o,
  output logic [lvl_w(DEPTH)-1:0]      level_o,
  output logic                         idle_o,
  output logic                         sample_o,
  output logic                         overrun_o
);

  localparam int NW = $clog2(DATA_W + 1);
  localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  logic              d0_q, d1_q, c0_q, c1_q;
  logic [BAUD_W-1:0] cnt_q, cnt_d;
  logic [NW-1:0]     left_q, left_d, len_q, len_d;
  logic              msb_q, msb_d;
  logic [DATA_W-1:0] asm_q, asm_d;
  logic              push_q, push_d;
  logic              ovr_q, ovr_d;

  logic              edge_ev, idle, smp;
  logic [NW-1:0]     nbits, pos;
  logic              full, empty, pop, drop;

  assign edge_ev = (d0_q ^ d1_q) | (c0_q & ~c1_q);
  assign idle    = (left_q == '0);
  assign smp     = ~idle & (cnt_q == '0) & ~edge_ev;
  assign nbits   = (bits_i > NW'(DATA_W)) ? NW'(DATA_W) : bits_i;
  // Arrival index k = len - left; MSB-first mirrors it to len-1-k = left-1.
  assign pos     = msb_q ? (left_q - NW'(1)) : (len_q - left_q);

  always_comb begin
    cnt_d  = cnt_q;
    left_d = left_q;
    len_d  = len_q;
    msb_d  = msb_q;
    asm_d  = asm_q;
    push_d = 1'b0;
    if (edge_ev) begin
      cnt_d = baud_i >> 1;
      if (idle) begin
        left_d = nbits;
        len_d  = nbits;
        msb_d  = msb_first_i;
        asm_d  = '0;
      end
    end else if (idle) begin
      cnt_d = baud_i;
    end else if (cnt_q == '0) begin
      cnt_d             = baud_i;
      left_d            = left_q - NW'(1);
      asm_d[pos[IW-1:0]] = d0_q;
      push_d            = (left_q == NW'(1));
    end else begin
      cnt_d = cnt_q - BAUD_W'(1);
    end
  end

  assign rx_valid_o = ~empty;
  assign pop        = rx_valid_o & rx_ready_i;
  assign drop       = push_q & full & ~pop;

  always_comb begin
    ovr_d = ovr_q;
    if (drop)           ovr_d = 1'b1;
    else if (ovr_clr_i) ovr_d = 1'b0;
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      d0_q   <= 1'b1;
      d1_q   <= 1'b1;
      c0_q   <= 1'b1;
      c1_q   <= 1'b1;
      cnt_q  <= '0;
      left_q <= '0;
      len_q  <= '0;
      msb_q  <= 1'b0;
      asm_q  <= '0;
      push_q <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      d0_q   <= rxd_i;
      d1_q   <= d0_q;
      c0_q   <= rxc_i;
      c1_q   <= c0_q;
      cnt_q  <= cnt_d;
      left_q <= left_d;
      len_q  <= len_d;
      msb_q  <= msb_d;
      asm_q  <= asm_d;
      push_q <= push_d;
      ovr_q  <= ovr_d;
    end
  end

  xsr_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .push_i  (push_q),
    .wdata_i (asm_q),
    .pop_i   (pop),
    .rdata_o (rx_data_o),
    .full_o  (full),
    .empty_o (empty),
    .level_o (level_o)
  );

  assign idle_o    = idle;
  assign sample_o  = smp;
  assign overrun_o = ovr_q;

endmodule

// File: tb/tb_xsr_rxq.sv
// Directed bench for xsr_rxq with DATA_W=8, DEPTH=4.
module tb_xsr_rxq;

  logic       clk_i = 1'b0;
  logic       reset_i;
  logic [3:0] bits_i;
  logic [15:0] baud_i;
  logic       msb_first_i, rxd_i, rxc_i, rx_ready_i, ovr_clr_i;
  logic [7:0] rx_data_o;
  logic       rx_valid_o, idle_o, sample_o, overrun_o;
  logic [2:0] level_o;

  int checks = 0;
  int fails  = 0;
  int cyc = 0, samp_cnt = 0, off_bad = 0, bit_start = 0;

  xsr_rxq #(.DATA_W(8), .BAUD_W(16), .DEPTH(4)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .bits_i(bits_i), .baud_i(baud_i),
    .msb_first_i(msb_first_i), .rxd_i(rxd_i), .rxc_i(rxc_i),
    .rx_ready_i(rx_ready_i), .ovr_clr_i(ovr_clr_i), .rx_data_o(rx_data_o),
    .rx_valid_o(rx_valid_o), .level_o(level_o), .idle_o(idle_o),
    .sample_o(sample_o), .overrun_o(overrun_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  // Sample pulses and their position inside the bit cell being driven.
  always @(negedge clk_i) begin
    if (sample_o === 1'b1) begin
      samp_cnt <= samp_cnt + 1;
      if ((cyc - bit_start) < 8 || (cyc - bit_start) > 14) off_bad <= off_bad + 1;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // Arrival bit k is s[k]; the line is first parked opposite s[0] with bits_i=0.
  task automatic send_frame(input logic [7:0] s, input int n, input int nsend,
                            input logic msb, input int baud, input logic pop_end,
                            output logic v0, output logic v1);
    int t;
    v0 = 1'b0;
    v1 = 1'b0;
    @(negedge clk_i);
    bits_i = 4'd0; msb_first_i = msb; baud_i = 16'(baud); rxd_i = ~s[0];
    repeat (4) @(negedge clk_i);
    bits_i = 4'(n);
    for (int k = 0; k < nsend; k++) begin
      rxd_i = s[k];
      bit_start = cyc;
      if (k == n - 1) begin
        t = 0;
        while (idle_o !== 1'b1 && t < 2 * baud) begin
          @(negedge clk_i);
          t++;
        end
        checks++;
        if (idle_o !== 1'b1) begin
          fails++;
          $display("FAIL frame_end idle_o=%b expected 1", idle_o);
        end
        v0 = rx_valid_o;
        if (pop_end) rx_ready_i = 1'b1;
        @(negedge clk_i);
        rx_ready_i = 1'b0;
        v1 = rx_valid_o;
        repeat (baud) @(negedge clk_i);
      end else begin
        repeat (baud) @(negedge clk_i);
      end
    end
  endtask

  task automatic pop1();
    @(negedge clk_i);
    rx_ready_i = 1'b1;
    @(negedge clk_i);
    rx_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    reset_i = 1'b0; bits_i = 4'd0; baud_i = 16'd16; msb_first_i = 1'b0;
    rxd_i = 1'b0; rxc_i = 1'b0; rx_ready_i = 1'b0; ovr_clr_i = 1'b0;
    repeat (2) @(negedge clk_i);
    checks++; if (rx_valid_o !== 1'b0) begin fails++; $display("FAIL rst_valid got=%b exp=0", rx_valid_o); end
    checks++; if (level_o !== 3'd0)    begin fails++; $display("FAIL rst_level got=%0d exp=0", level_o); end
    checks++; if (idle_o !== 1'b1)     begin fails++; $display("FAIL rst_idle got=%b exp=1", idle_o); end
    checks++; if (sample_o !== 1'b0)   begin fails++; $display("FAIL rst_sample got=%b exp=0", sample_o); end
    checks++; if (rx_data_o !== 8'h00) begin fails++; $display("FAIL rst_data got=%h exp=00", rx_data_o); end
    checks++; if (overrun_o !== 1'b0)  begin fails++; $display("FAIL rst_ovr got=%b exp=0", overrun_o); end
    reset_i = 1'b1;
    // rxd_i=0 against the reset value 1 makes an edge event with bits_i=0.
    repeat (6) @(negedge clk_i);
    checks++; if (idle_o !== 1'b1)     begin fails++; $display("FAIL zero_bits_idle got=%b exp=1", idle_o); end
    checks++; if (sample_o !== 1'b0)   begin fails++; $display("FAIL zero_bits_sample got=%b exp=0", sample_o); end
  endtask

  task automatic test_lsb();
    int s0, b0;
    logic v0, v1;
    s0 = samp_cnt; b0 = off_bad;
    send_frame(8'hA5, 8, 8, 1'b0, 16, 1'b0, v0, v1);
    checks++; if (samp_cnt - s0 != 8) begin fails++; $display("FAIL lsb_samples got=%0d exp=8", samp_cnt - s0); end
    checks++; if (off_bad - b0 != 0)  begin fails++; $display("FAIL lsb_midbit got=%0d exp=0", off_bad - b0); end
    checks++; if (v0 !== 1'b0)        begin fails++; $display("FAIL lsb_lat0 got=%b exp=0", v0); end
    checks++; if (v1 !== 1'b1)        begin fails++; $display("FAIL lsb_lat1 got=%b exp=1", v1); end
    checks++; if (rx_data_o !== 8'hA5) begin fails++; $display("FAIL lsb_data got=%h exp=a5", rx_data_o); end
    checks++; if (level_o !== 3'd1)   begin fails++; $display("FAIL lsb_level got=%0d exp=1", level_o); end
    pop1();
    checks++; if (level_o !== 3'd0)   begin fails++; $display("FAIL lsb_pop got=%0d exp=0", level_o); end
  endtask

  task automatic test_msb5();
    int s0;
    logic v0, v1;
    s0 = samp_cnt;
    send_frame(8'hA5, 5, 5, 1'b1, 16, 1'b0, v0, v1);
    checks++; if (samp_cnt - s0 != 5)  begin fails++; $display("FAIL msb_samples got=%0d exp=5", samp_cnt - s0); end
    checks++; if (rx_data_o !== 8'h14) begin fails++; $display("FAIL msb_data got=%h exp=14", rx_data_o); end
    checks++; if (rx_data_o[7:5] !== 3'b000) begin fails++; $display("FAIL msb_upper got=%b exp=000", rx_data_o[7:5]); end
    pop1();
  endtask

  task automatic test_overrun();
    logic [7:0] fr [5];
    logic v0, v1;
    fr = '{8'h69, 8'h96, 8'hA5, 8'h5A, 8'h33};
    for (int i = 0; i < 5; i++) send_frame(fr[i], 8, 8, 1'b0, 16, 1'b0, v0, v1);
    checks++; if (level_o !== 3'd4)    begin fails++; $display("FAIL ovr_level got=%0d exp=4", level_o); end
    checks++; if (overrun_o !== 1'b1)  begin fails++; $display("FAIL ovr_flag got=%b exp=1", overrun_o); end
    checks++; if (rx_data_o !== 8'h69) begin fails++; $display("FAIL ovr_head got=%h exp=69", rx_data_o); end
    @(negedge clk_i); ovr_clr_i = 1'b1;
    @(negedge clk_i); ovr_clr_i = 1'b0;
    checks++; if (overrun_o !== 1'b0)  begin fails++; $display("FAIL ovr_clr got=%b exp=0", overrun_o); end
    checks++; if (level_o !== 3'd4)    begin fails++; $display("FAIL ovr_clr_level got=%0d exp=4", level_o); end
  endtask

  task automatic test_full_pushpop();
    logic [7:0] ex [4];
    logic v0, v1;
    ex = '{8'h96, 8'hA5, 8'h5A, 8'h6A};
    send_frame(8'h6A, 8, 8, 1'b0, 16, 1'b1, v0, v1);
    checks++; if (level_o !== 3'd4)    begin fails++; $display("FAIL full_level got=%0d exp=4", level_o); end
    checks++; if (overrun_o !== 1'b0)  begin fails++; $display("FAIL full_ovr got=%b exp=0", overrun_o); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (rx_data_o !== ex[i]) begin fails++; $display("FAIL drain_data%0d got=%h exp=%h", i, rx_data_o, ex[i]); end
      pop1();
      checks++; if (level_o !== 3'(3 - i)) begin fails++; $display("FAIL drain_level%0d got=%0d exp=%0d", i, level_o, 3 - i); end
    end
    checks++; if (rx_valid_o !== 1'b0) begin fails++; $display("FAIL drain_valid got=%b exp=0", rx_valid_o); end
  endtask

  task automatic test_resync();
    int t, first;
    @(negedge clk_i);
    bits_i = 4'd0; msb_first_i = 1'b0; baud_i = 16'd20; rxd_i = 1'b1;
    repeat (4) @(negedge clk_i);
    bits_i = 4'd8; rxd_i = 1'b0;
    t = 0;
    while (sample_o !== 1'b1 && t < 40) begin @(negedge clk_i); t++; end
    checks++; if (sample_o !== 1'b1) begin fails++; $display("FAIL resync_first got=%b exp=1", sample_o); end
    repeat (5) @(negedge clk_i);
    rxc_i = 1'b1;
    @(posedge clk_i);
    @(posedge clk_i);
    first = -1;
    for (int j = 0; j < 15; j++) begin
      @(negedge clk_i);
      if (sample_o === 1'b1 && first < 0) first = j;
    end
    rxc_i = 1'b0;
    checks++; if (first != 10) begin fails++; $display("FAIL resync_delay got=%0d exp=10", first); end
    t = 0;
    while (idle_o !== 1'b1 && t < 300) begin @(negedge clk_i); t++; end
    @(negedge clk_i);
    checks++; if (level_o !== 3'd1)    begin fails++; $display("FAIL resync_level got=%0d exp=1", level_o); end
    checks++; if (rx_data_o !== 8'h00) begin fails++; $display("FAIL resync_data got=%h exp=00", rx_data_o); end
  endtask

  task automatic test_reset_mid();
    int s0;
    logic v0, v1;
    s0 = samp_cnt;
    send_frame(8'hA5, 8, 3, 1'b0, 16, 1'b0, v0, v1);
    checks++; if (samp_cnt - s0 != 3) begin fails++; $display("FAIL mid_samples got=%0d exp=3", samp_cnt - s0); end
    checks++; if (idle_o !== 1'b0)    begin fails++; $display("FAIL mid_busy got=%b exp=0", idle_o); end
    reset_i = 1'b0;
    #1;
    checks++; if (idle_o !== 1'b1)     begin fails++; $display("FAIL mid_rst_idle got=%b exp=1", idle_o); end
    checks++; if (level_o !== 3'd0)    begin fails++; $display("FAIL mid_rst_level got=%0d exp=0", level_o); end
    checks++; if (rx_valid_o !== 1'b0) begin fails++; $display("FAIL mid_rst_valid got=%b exp=0", rx_valid_o); end
    @(negedge clk_i);
    reset_i = 1'b1;
    repeat (30) @(negedge clk_i);
    checks++; if (level_o !== 3'd0)    begin fails++; $display("FAIL mid_nopush got=%0d exp=0", level_o); end
    s0 = samp_cnt;
    send_frame(8'h5A, 8, 8, 1'b0, 16, 1'b0, v0, v1);
    checks++; if (rx_data_o !== 8'h5A) begin fails++; $display("FAIL post_rst_data got=%h exp=5a", rx_data_o); end
    checks++; if (level_o !== 3'd1)    begin fails++; $display("FAIL post_rst_level got=%0d exp=1", level_o); end
    checks++; if (samp_cnt - s0 != 8)  begin fails++; $display("FAIL post_rst_samples got=%0d exp=8", samp_cnt - s0); end
  endtask

  initial begin
    test_reset();
    test_lsb();
    test_msb5();
    test_overrun();
    test_full_pushpop();
    test_resync();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
